board_memory_rw: RTL

- Parametrised, clocked successor to the purely combinational board-cell read mux.
- Stores BOARD_N x BOARD_N cells of CELL_W bits each.
- Provides one registered read port, one write port that checks occupancy, and a multi-cycle board clear sequencer.
- Exposes the whole board as a flat vector for the display and win-check logic.
- Sits between the game controller (places stones) and the renderer/referee (read cells).

---
 rtl/board_memory_rw.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/board_memory_rw.sv
// BOARD_N x BOARD_N game board store: registered read port, occupancy-checked write port,
// row-per-cycle clear sequencer and flat board view. Optional line scan: BOARD_MEMORY_LINE_SCAN_EN.
module board_memory_rw #(
  parameter int BOARD_N = 16,
  parameter int CELL_W  = 2,
  parameter int COORD_W = 4
`ifdef BOARD_MEMORY_LINE_SCAN_EN
  ,
  parameter int SCAN_LEN = 5
`endif
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              rd_req,
  input  logic [2*COORD_W-1:0]              rd_sel,
  output logic                              rd_valid,
  output logic [CELL_W-1:0]                 rd_data,
  input  logic                              wr_req,
  input  logic [2*COORD_W-1:0]              wr_sel,
  input  logic [CELL_W-1:0]                 wr_data,
  input  logic                              wr_force,
  output logic                              wr_ack,
  output logic                              wr_reject,
  input  logic                              clr_req,
  output logic                              busy,
  output logic [BOARD_N*BOARD_N*CELL_W-1:0] board_flat
`ifdef BOARD_MEMORY_LINE_SCAN_EN
  ,
  input  logic                              scan_req,
  input  logic [2*COORD_W-1:0]              scan_sel,
  input  logic [1:0]                        scan_dir,
  output logic                              scan_valid,
  output logic [CELL_W-1:0]                 scan_data,
  output logic                              scan_last,
  output logic                              scan_busy
`endif
);

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  logic [CELL_W-1:0]  mem_q [CELLS];
  logic [CELL_W-1:0]  mem_d [CELLS];
  state_t             state_q, state_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic               busy_q, busy_d;
  logic               rd_valid_q, rd_valid_d;
  logic [CELL_W-1:0]  rd_data_q, rd_data_d;
  logic               wr_ack_q, wr_ack_d;
  logic               wr_reject_q, wr_reject_d;

  logic [COORD_W-1:0] rd_x, rd_y, wr_x, wr_y;
  logic               wr_ok;

  function automatic logic coord_ok(input logic [COORD_W-1:0] c);
    return {1'b0, c} < (COORD_W+1)'(BOARD_N);
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    return IDX_W'(int'(x) * BOARD_N + int'(y));
  endfunction

  assign rd_x = rd_sel[2*COORD_W-1:COORD_W];
  assign rd_y = rd_sel[COORD_W-1:0];
  assign wr_x = wr_sel[2*COORD_W-1:COORD_W];
  assign wr_y = wr_sel[COORD_W-1:0];

  // Occupancy test uses the pre-edge contents, so a same-cycle read sees the old value too.
  assign wr_ok = !busy_q && !clr_req && coord_ok(wr_x) && coord_ok(wr_y) &&
                 ((mem_q[cell_idx(wr_x, wr_y)] == '0) || wr_force);

  always_comb begin
    mem_d       = mem_q;
    state_d     = state_q;
    row_d       = row_q;
    rd_valid_d  = rd_req;
    rd_data_d   = rd_data_q;
    wr_ack_d    = 1'b0;
    wr_reject_d = 1'b0;

    if (rd_req) begin
      if (coord_ok(rd_x) && coord_ok(rd_y)) begin
        rd_data_d = mem_q[cell_idx(rd_x, rd_y)];
      end else begin
        rd_data_d = '0;
      end
    end

    if (wr_req) begin
      if (wr_ok) begin
        mem_d[cell_idx(wr_x, wr_y)] = wr_data;
        wr_ack_d = 1'b1;
      end else begin
        wr_reject_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          row_d   = '0;
        end
      end
      S_CLEAR: begin
        for (int y = 0; y < BOARD_N; y++) begin
          mem_d[IDX_W'(int'(row_q) * BOARD_N + y)] = '0;
        end
        if (row_q == COORD_W'(BOARD_N - 1)) begin
          state_d = S_IDLE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) begin
        mem_q[i] <= '0;
      end
      state_q     <= S_IDLE;
      row_q       <= '0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      wr_ack_q    <= 1'b0;
      wr_reject_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      state_q     <= state_d;
      row_q       <= row_d;
      busy_q      <= busy_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      wr_ack_q    <= wr_ack_d;
      wr_reject_q <= wr_reject_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign wr_ack    = wr_ack_q;
  assign wr_reject = wr_reject_q;
  assign busy      = busy_q;

  for (genvar g = 0; g < CELLS; g++) begin : g_flat
    assign board_flat[g*CELL_W +: CELL_W] = mem_q[g];
  end

`ifdef BOARD_MEMORY_LINE_SCAN_EN
  localparam int PW     = COORD_W + 2;
  localparam int SCNT_W = $clog2(SCAN_LEN + 1);

  logic                  scan_busy_q, scan_busy_d;
  logic                  scan_valid_q, scan_valid_d;
  logic                  scan_last_q, scan_last_d;
  logic [CELL_W-1:0]     scan_data_q, scan_data_d;
  logic [SCNT_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic signed [PW-1:0]  scan_x_q, scan_x_d, scan_y_q, scan_y_d;
  logic signed [PW-1:0]  scan_dx_q, scan_dx_d, scan_dy_q, scan_dy_d;
  logic                  scan_go;
  logic signed [PW-1:0]  sx_cur, sy_cur, sdx_cur, sdy_cur;
  logic [SCNT_W-1:0]     scnt_cur;

  // Positions carry two extra bits so stepping past either edge stays detectable.
  function automatic logic [CELL_W-1:0] scan_cell(input logic signed [PW-1:0] x,
                                                  input logic signed [PW-1:0] y);
    if (x[PW-1] || y[PW-1] || int'(x) >= BOARD_N || int'(y) >= BOARD_N) begin
      return '1;
    end
    return mem_q[IDX_W'(int'(x) * BOARD_N + int'(y))];
  endfunction

  always_comb begin
    scan_busy_d  = scan_busy_q;
    scan_valid_d = 1'b0;
    scan_last_d  = 1'b0;
    scan_data_d  = scan_data_q;
    scan_cnt_d   = scan_cnt_q;
    scan_x_d     = scan_x_q;
    scan_y_d     = scan_y_q;
    scan_dx_d    = scan_dx_q;
    scan_dy_d    = scan_dy_q;
    scan_go      = 1'b0;
    sx_cur       = scan_x_q;
    sy_cur       = scan_y_q;
    sdx_cur      = scan_dx_q;
    sdy_cur      = scan_dy_q;
    scnt_cur     = scan_cnt_q;

    if (scan_busy_q) begin
      if (clr_req || scan_cnt_q == SCNT_W'(SCAN_LEN)) begin
        scan_busy_d = 1'b0;
      end else begin
        scan_go = 1'b1;
      end
    end else if (scan_req && !busy_q && !clr_req) begin
      scan_go     = 1'b1;
      scan_busy_d = 1'b1;
      scnt_cur    = '0;
      sx_cur      = signed'({2'b00, scan_sel[2*COORD_W-1:COORD_W]});
      sy_cur      = signed'({2'b00, scan_sel[COORD_W-1:0]});
      case (scan_dir)
        2'd0:    begin sdx_cur = '0;       sdy_cur = PW'(1); end
        2'd1:    begin sdx_cur = PW'(1);   sdy_cur = '0;     end
        2'd2:    begin sdx_cur = PW'(1);   sdy_cur = PW'(1); end
        default: begin sdx_cur = PW'(1);   sdy_cur = '1;     end
      endcase
    end

    if (scan_go) begin
      scan_valid_d = 1'b1;
      scan_data_d  = scan_cell(sx_cur, sy_cur);
      scan_last_d  = (scnt_cur == SCNT_W'(SCAN_LEN - 1));
      scan_x_d     = sx_cur + sdx_cur;
      scan_y_d     = sy_cur + sdy_cur;
      scan_dx_d    = sdx_cur;
      scan_dy_d    = sdy_cur;
      scan_cnt_d   = scnt_cur + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_busy_q  <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_last_q  <= 1'b0;
      scan_data_q  <= '0;
      scan_cnt_q   <= '0;
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      scan_dx_q    <= '0;
      scan_dy_q    <= '0;
    end else begin
      scan_busy_q  <= scan_busy_d;
      scan_valid_q <= scan_valid_d;
      scan_last_q  <= scan_last_d;
      scan_data_q  <= scan_data_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_x_q     <= scan_x_d;
      scan_y_q     <= scan_y_d;
      scan_dx_q    <= scan_dx_d;
      scan_dy_q    <= scan_dy_d;
    end
  end

  assign scan_valid = scan_valid_q;
  assign scan_data  = scan_data_q;
  assign scan_last  = scan_last_q;
  assign scan_busy  = scan_busy_q;
`endif

endmodule
